// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the successive-approximation ADC.
package sar_adc_pkg;

   typedef enum logic [1:0] {IDLE, CONV, DONE} sar_state_t;

   localparam int SAR_N_DEFAULT = 3;

endpackage

// File: rtl/r_string_dac.sv
// Ideal resistor-string DAC: vout_c = code * vref / 2^n, used as the SAR feedback path.
module r_string_dac #(
   parameter int n = 3
) (
   input  logic [n-1:0] code,
   input  real          vref,
   output real          vout_c
);

   localparam real NLEVELS = 2.0 ** n;

   always_comb begin
      vout_c = real'(code) * vref / NLEVELS;
   end

endmodule

// File: rtl/sar_adc.sv
// N-bit SAR ADC: one bit decided per clock against an ideal r_string_dac.
// Optional out-of-range flag enabled by defining SAR_ADC_OVR_EN.
module sar_adc
   import sar_adc_pkg::*;
#(
   parameter int N = SAR_N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  real          VIN,
   input  real          VSUP,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Q
`ifdef SAR_ADC_OVR_EN
   ,
   output logic         ovr
`endif
);

   localparam real         NLEVELS = 2.0 ** N;
   localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;

   sar_state_t    state_q, state_d;
   logic [N-1:0]  sar_q, sar_d;
   logic [IW-1:0] bit_idx_q, bit_idx_d;
   real           vin_s_q, vin_s_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [N-1:0]  q_q, q_d;
   logic [N-1:0]  trial_c;
   real           vdac_c;
`ifdef SAR_ADC_OVR_EN
   logic          ovr_q, ovr_d;
`endif

   r_string_dac #(.n(N)) u_dac (
      .code   (trial_c),
      .vref   (VSUP),
      .vout_c (vdac_c)
   );

   // Trial code: bits already kept plus the bit under test.
   always_comb begin
      trial_c = sar_q | (N'(1) << bit_idx_q);
   end

   always_comb begin
      state_d   = state_q;
      sar_d     = sar_q;
      bit_idx_d = bit_idx_q;
      vin_s_d   = vin_s_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      q_d       = q_q;
`ifdef SAR_ADC_OVR_EN
      ovr_d     = ovr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               vin_s_d   = VIN;
               sar_d     = '0;
               bit_idx_d = IW'(N - 1);
               busy_d    = 1'b1;
               state_d   = CONV;
            end
         end
         CONV: begin
            if (vin_s_q >= vdac_c) sar_d = trial_c;
            if (bit_idx_q == '0) begin
               q_d     = sar_d;
               done_d  = 1'b1;
               state_d = DONE;
`ifdef SAR_ADC_OVR_EN
               ovr_d   = (vin_s_q >= VSUP) || (vin_s_q < 0.0);
`endif
            end else begin
               bit_idx_d = bit_idx_q - IW'(1);
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sar_q     <= '0;
         bit_idx_q <= '0;
         vin_s_q   <= 0.0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         q_q       <= '0;
`ifdef SAR_ADC_OVR_EN
         ovr_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sar_q     <= sar_d;
         bit_idx_q <= bit_idx_d;
         vin_s_q   <= vin_s_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         q_q       <= q_d;
`ifdef SAR_ADC_OVR_EN
         ovr_q     <= ovr_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Q    = q_q;
`ifdef SAR_ADC_OVR_EN
   assign ovr  = ovr_q;
`endif

`ifdef FORMAL
   // The result brackets the sampled input within one LSB, saturating at full scale.
   always @(posedge clk) begin
      if (rst_n && done_q) begin
         assert ((real'(q_q) * (VSUP / NLEVELS) <= vin_s_q) &&
                 ((q_q == '1) || (vin_s_q < real'(q_q + N'(1)) * (VSUP / NLEVELS))));
      end
   end
`endif

endmodule
